// File: rtl/adder_lab_pkg.sv
// Shared types for the adders lab: FSM state encoding of the serial sequencer.
package adder_lab_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the whole datapath of the serial sequencer.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   // Sum and majority carry.
   always_comb begin
      s    = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: operands are captured on start and fed
// LSB-first through one full adder, one bit per cycle, with a registered carry.
// Results (sum, cout, overflow) only update on the final bit, so the display
// never sees partial values.
module serial_adder_ctrl
   import adder_lab_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLOCK_50,
   input  logic             RESET,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH);
   // Counter value on the final (MSB) edge and on the edge just before it.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 2);

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_opa;
   logic [WIDTH-1:0]   r_opb;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_sum;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carry;
   logic               r_cmsb;
   logic               r_cout;
   logic               r_ovf;
   logic               w_s;
   logic               w_c;
   logic               w_last;
   logic               w_accept;
   logic [WIDTH-1:0]   w_acc_nxt;

   full_adder u_fa (
      .a    (r_opa[0]),
      .b    (r_opb[0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_c)
   );

   assign w_last    = (r_cnt == CNT_LAST);
   // Accumulator shifts the new sum bit in at the MSB end.
   assign w_acc_nxt = WIDTH'({w_s, r_acc} >> 1);

   // State register.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next state and handshake outputs; start is only looked at outside RUN.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (r_state)
         IDLE: begin
            w_accept = start;
            if (start) w_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) w_next = DONE;
         end
         DONE: begin
            done     = 1'b1;
            w_accept = start;
            w_next   = start ? RUN : IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Operand capture, serial shift, carry chain and result publication.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         r_opa   <= '0;
         r_opb   <= '0;
         r_acc   <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cmsb  <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         // Subtraction is a + ~b + 1: invert B and preload the carry.
         r_opa   <= a;
         r_opb   <= sub ? ~b : b;
         r_carry <= sub;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_carry <= w_c;
         r_opa   <= r_opa >> 1;
         r_opb   <= r_opb >> 1;
         r_acc   <= w_acc_nxt;
         if (!w_last) r_cnt <= r_cnt + 1'b1;
         // Carry into the MSB, needed for signed overflow on the last bit.
         if (r_cnt == CNT_MSB) r_cmsb <= w_c;
         if (w_last) begin
            r_sum  <= w_acc_nxt;
            r_cout <= w_c;
            r_ovf  <= r_cmsb ^ w_c;
         end
      end
   end

   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases, random operations,
// mid-op reset, back-to-back with operand changes, and a WIDTH=2 instance.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, sub;
   logic [7:0] a, b;
   logic       busy, done, cout, ovf;
   logic [7:0] sum;

   logic       start2, sub2;
   logic [1:0] a2, b2;
   logic       busy2, done2, cout2, ovf2;
   logic [1:0] sum2;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] prev_sum;
   logic       prev_cout, prev_ovf;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .CLOCK_50 (clk), .RESET (rst), .start (start), .sub (sub),
      .a (a), .b (b), .busy (busy), .done (done),
      .sum (sum), .cout (cout), .overflow (ovf)
   );

   serial_adder_ctrl #(.WIDTH(2)) dut2 (
      .CLOCK_50 (clk), .RESET (rst), .start (start2), .sub (sub2),
      .a (a2), .b (b2), .busy (busy2), .done (done2),
      .sum (sum2), .cout (cout2), .overflow (ovf2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on w-bit values.
   function automatic void model(input int w, input longint x, input longint y, input logic s,
                                 output logic [31:0] es, output logic ec, output logic eo);
      longint m    = (longint'(1) << w);
      longint half = m / 2;
      longint sx   = (x >= half) ? x - m : x;
      longint sy   = (y >= half) ? y - m : y;
      longint r    = s ? (sx - sy) : (sx + sy);
      longint u    = s ? (x - y + m) : (x + y);
      es = 32'(u % m);
      ec = s ? (x >= y) : (u >= m);
      eo = (r > half - 1) || (r < -half);
   endfunction

   // Full single operation with cycle-accurate handshake checks.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts);
      logic [31:0] es;
      logic        ec, eo;
      model(8, longint'(ta), longint'(tb), ts, es, ec, eo);
      start = 1'b1; a = ta; b = tb; sub = ts;
      @(posedge clk); #1;
      start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      for (int i = 0; i < 8; i++) begin
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
         chk("sum_held", sum, prev_sum);
         @(posedge clk); #1;
      end
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 0);
      chk("sum", sum, es);
      chk("cout", cout, ec);
      chk("ovf", ovf, eo);
      prev_sum = sum; prev_cout = cout; prev_ovf = ovf;
      @(posedge clk); #1;
      chk("done_clear", done, 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      logic [7:0]  qa[5], qb[5];
      logic        qs[5];
      logic [31:0] es;
      logic        ec, eo;

      rst = 1'b1; start = 0; sub = 0; a = 0; b = 0;
      start2 = 0; sub2 = 0; a2 = 0; b2 = 0;
      prev_sum = 0; prev_cout = 0; prev_ovf = 0;
      #22;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases.
      do_op(8'h3C, 8'h55, 1'b0);
      do_op(8'h10, 8'h20, 1'b1);
      do_op(8'hFF, 8'h01, 1'b0);
      do_op(8'h80, 8'h01, 1'b1);
      do_op(8'h7F, 8'h7F, 1'b0);
      do_op(8'h00, 8'h00, 1'b1);

      // Random operations.
      for (int k = 0; k < 25; k++)
         do_op(8'($urandom), 8'($urandom), 1'($urandom));

      // Reset in the middle of an operation.
      start = 1'b1; a = 8'hAA; b = 8'h77; sub = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_cout", cout, 0);
      chk("mid_rst_ovf", ovf, 0);
      @(negedge clk); rst = 1'b0;
      prev_sum = 0; prev_cout = 0; prev_ovf = 0;
      @(posedge clk); #1;
      do_op(8'h02, 8'h03, 1'b0);

      // Back-to-back: start held high, operands changed while running.
      for (int k = 0; k < 5; k++) begin
         qa[k] = 8'($urandom); qb[k] = 8'($urandom); qs[k] = 1'($urandom);
      end
      start = 1'b1; a = qa[0]; b = qb[0]; sub = qs[0];
      @(posedge clk); #1;
      a = qa[1]; b = qb[1]; sub = qs[1];
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 8; i++) begin
            chk("b2b_busy", busy, 1);
            chk("b2b_done_low", done, 0);
            @(posedge clk); #1;
         end
         model(8, longint'(qa[k]), longint'(qb[k]), qs[k], es, ec, eo);
         chk("b2b_done", done, 1);
         chk("b2b_sum", sum, es);
         chk("b2b_cout", cout, ec);
         chk("b2b_ovf", ovf, eo);
         if (k == 3) start = 1'b0;
         @(posedge clk); #1;
         // DONE has just re-accepted; the next operand set is now don't-care
         // for the running op and becomes the following request.
         a = qa[k+1 < 4 ? k+2 : 4]; b = qb[k+1 < 4 ? k+2 : 4]; sub = qs[k+1 < 4 ? k+2 : 4];
         if (k < 3) chk("b2b_reaccept", busy, 1);
         else       chk("b2b_stop", busy, 0);
      end

      // WIDTH=2 instance: the specific case, then every operand pair.
      start2 = 1'b1; a2 = 2'b01; b2 = 2'b01; sub2 = 1'b0;
      @(posedge clk); #1; start2 = 1'b0;
      chk("w2_busy0", busy2, 1);
      @(posedge clk); #1;
      chk("w2_busy1", busy2, 1);
      chk("w2_done_low", done2, 0);
      @(posedge clk); #1;
      chk("w2_done", done2, 1);
      chk("w2_sum", sum2, 2'b10);
      chk("w2_cout", cout2, 0);
      chk("w2_ovf", ovf2, 1);
      @(posedge clk); #1;
      for (int v = 0; v < 32; v++) begin
         logic [4:0] vv;
         vv = 5'(v);
         model(2, longint'(vv[1:0]), longint'(vv[3:2]), vv[4], es, ec, eo);
         start2 = 1'b1; a2 = vv[1:0]; b2 = vv[3:2]; sub2 = vv[4];
         @(posedge clk); #1; start2 = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         chk("w2x_done", done2, 1);
         chk("w2x_sum", sum2, es);
         chk("w2x_cout", cout2, ec);
         chk("w2x_ovf", ovf2, eo);
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
